dhs_scoreboard: RTL and testbench
=================================

// Module: dhs_scoreboard
// PURPOSE
//  Parametrised data-hazard stall unit for the pipelined datapath.
//  Keeps a DEPTH-entry scoreboard of in-flight register writes, compares the
//  decode-stage source addresses (AA/BA) against it and stalls decode while
//  a hazard exists.
//  Inserts bubbles into the scoreboard during a stall, counts stall cycles and
//  optionally resolves oldest-stage hazards by forwarding.
//  Sits between instruction decode and the PC/IR load enables.
// PARAMETERS
//  AW     3   register address width (2**AW registers; R0 never hazards)
//  DEPTH  2   stages between decode and writeback (scoreboard entries, >=1)
//  CW     8   stall-cycle counter width
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      async active-low reset
//  id_valid   in   1      decode stage holds a real instruction
//  MA         in   1      1 = A operand not from register file (no A hazard)
//  MB         in   1      1 = B operand not from register file (no B hazard)
//  RW         in   1      decode instruction writes register DA
//  AA         in   AW     source A address
//  BA         in   AW     source B address
//  DA         in   AW     destination address
//  flush      in   1      sync clear of all scoreboard entries (branch taken)
//  cnt_clr    in   1      sync clear of stall_cnt
//  DHS_O      out  1      1 = stall decode this cycle
//  DHS_I      out  1      ~DHS_O; PC/IR load enable
//  fwd_a      out  1      A operand forwarded from oldest stage (FWD_EN only)
//  fwd_b      out  1      B operand forwarded from oldest stage (FWD_EN only)
//  stall_cnt  out  CW     saturating count of stalled cycles
// BEHAVIOUR
//  - Scoreboard: slot[1..DEPTH] = {v, dst}; slot[1] youngest, slot[DEPTH] writes back next edge.
//  - match_a[k] = slot[k].v & (slot[k].dst==AA); match_b likewise with BA.
//  - HA = id_valid & ~MA & |match_a; HB = id_valid & ~MB & |match_b (comb).
//  - DHS_O = HA|HB, same cycle, no latency; DHS_I = ~DHS_O always.
//  - Each edge: slot[k+1]<=slot[k]; slot[1]<={id_valid & RW & ~DHS_O & (DA!=0), DA}.
//    During a stall slot[1] receives a bubble (v=0); decode holds its instruction.
//  - Writes to R0 are never entered (v=0), so a source of R0 never stalls.
//  - Max consecutive stall = DEPTH cycles (bubbles drain every entry); no deadlock.
//  - flush: all slots v<=0 at the edge, overrides the shift/push; the
//    instruction in decode that cycle is not entered. DHS_O still reflects
//    pre-flush slots that cycle.
//  - stall_cnt: +1 on each edge with DHS_O=1; saturates at 2**CW-1;
//    cnt_clr wins over increment (count -> 0).
//  - id_valid=0: no hazard, no push (bubble shifts in).
//  - Reset (async assert, sync-safe release): all slot.v=0, stall_cnt=0
//    -> DHS_O=0, DHS_I=1, fwd_a=fwd_b=0 while rst_n=0. Mid-stall reset drops the
//    stall immediately.
// CONFIGURATION
//  - Macro DHS_FWD_EN defined: a match only in slot[DEPTH] does not stall;
//    it asserts fwd_a/fwd_b instead. HA uses match_a[1..DEPTH-1] only, and
//    fwd_a = id_valid & ~MA & match_a[DEPTH] & ~HA & ~HB (fwd_b likewise).
//    A younger match still stalls; fwd_* are 0 during any stall.
//    With DEPTH=1 every hazard is forwarded and DHS_O is constant 0.
//  - Not defined: all slots are checked for stalls; fwd_a=fwd_b tied 0.
// TESTING (AW=3, DEPTH=2, CW=8)
//  1 Reset: rst_n=0 mid-stall -> DHS_O=0, DHS_I=1, stall_cnt=0 immediately.
//  2 RAW: cyc0 RW=1 DA=3; cyc1 AA=3 MA=0 -> DHS_O=1 for 2 cycles, then 0;
//    stall_cnt=2. With DHS_FWD_EN: 1 stall cycle, then fwd_a=1 for 1 cycle.
//  3 Masked: cyc0 DA=3 RW=1; cyc1 AA=3 MA=1, BA=3 MB=1 -> DHS_O=0.
//  4 R0: cyc0 RW=1 DA=0; cyc1 AA=0 BA=0 MA=MB=0 -> DHS_O=0.
//  5 Flush: cyc0 DA=5 RW=1; cyc1 flush=1; cyc2 BA=5 MB=0 -> DHS_O=0 at cyc2.
//  6 Saturate: force 260 stall cycles (CW=8) -> stall_cnt=255;
//    cnt_clr with DHS_O=1 -> 0.

Source files
------------

// File: rtl/dhs_scoreboard_if.sv
// -----------------------------------------------------------------------------
// dhs_scoreboard_if
// Purpose : groups the decode-side signals of the data-hazard stall unit.
//   master : decode stage. Drives the instruction fields and the flush/cnt_clr
//            controls, and receives the stall/forward results.
//   slave  : dhs_scoreboard. Receives the instruction fields and controls, and
//            drives DHS_O/DHS_I/fwd_a/fwd_b/stall_cnt.
// Signals :
//   id_valid, MA, MB, RW, AA, BA, DA : decode instruction fields
//   flush, cnt_clr                   : synchronous clears
//   DHS_O, DHS_I                     : stall request and PC/IR load enable
//   fwd_a, fwd_b                     : oldest-stage forward selects
//   stall_cnt                        : saturating stall-cycle count
// -----------------------------------------------------------------------------
interface dhs_scoreboard_if #(
  parameter int AW = 3,
  parameter int CW = 8
);
  logic          id_valid;
  logic          MA;
  logic          MB;
  logic          RW;
  logic [AW-1:0] AA;
  logic [AW-1:0] BA;
  logic [AW-1:0] DA;
  logic          flush;
  logic          cnt_clr;
  logic          DHS_O;
  logic          DHS_I;
  logic          fwd_a;
  logic          fwd_b;
  logic [CW-1:0] stall_cnt;

  modport master (
    output id_valid, MA, MB, RW, AA, BA, DA, flush, cnt_clr,
    input  DHS_O, DHS_I, fwd_a, fwd_b, stall_cnt
  );

  modport slave (
    input  id_valid, MA, MB, RW, AA, BA, DA, flush, cnt_clr,
    output DHS_O, DHS_I, fwd_a, fwd_b, stall_cnt
  );
endinterface

// File: rtl/dhs_scoreboard.sv
// -----------------------------------------------------------------------------
// dhs_scoreboard
// Purpose : data-hazard stall unit. It keeps a DEPTH-entry scoreboard of
//   in-flight register writes and compares the decode source addresses
//   against it. It stalls decode while a hazard exists, and counts the
//   stalled cycles in a saturating counter.
// Ports   :
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : dhs_scoreboard_if.slave. Carries the decode fields and the
//           flush/cnt_clr inputs, and the DHS_O/DHS_I/fwd_a/fwd_b/stall_cnt
//           outputs.
// Parameters : AW (address width), DEPTH (stages to writeback), CW (counter
//   width).
// Option  : define DHS_FWD_EN to forward from the oldest slot instead of
//   stalling on it. When it is not defined, every slot stalls and
//   fwd_a/fwd_b are tied to 0.
// Note    : DHS_O is a same-cycle combinational decode of the registered
//   scoreboard. Decode must see the stall in the cycle in which the hazard
//   appears.
// -----------------------------------------------------------------------------
module dhs_scoreboard #(
  parameter int AW    = 3,
  parameter int DEPTH = 2,
  parameter int CW    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  dhs_scoreboard_if.slave  bus
);

`ifdef DHS_FWD_EN
  // The oldest slot is resolved by forwarding, so it is masked out of the stall check.
  localparam logic [DEPTH:1] STALL_MASK = {DEPTH{1'b1}} >> 1'b1;
`else
  localparam logic [DEPTH:1] STALL_MASK = {DEPTH{1'b1}};
`endif

  logic [DEPTH:1]  slot_v_r;
  logic [AW-1:0]   slot_dst_r [1:DEPTH];
  logic [CW-1:0]   stall_cnt_r;
  logic [DEPTH:1]  match_a_s;
  logic [DEPTH:1]  match_b_s;
  logic            ha_s;
  logic            hb_s;
  logic            stall_s;
  logic            push_s;

  // Compare the decode source addresses with every scoreboard slot.
  always_comb begin
    match_a_s = '0;
    match_b_s = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      match_a_s[k] = slot_v_r[k] & (slot_dst_r[k] == bus.AA);
      match_b_s[k] = slot_v_r[k] & (slot_dst_r[k] == bus.BA);
    end
  end

  assign ha_s    = bus.id_valid & ~bus.MA & (|(match_a_s & STALL_MASK));
  assign hb_s    = bus.id_valid & ~bus.MB & (|(match_b_s & STALL_MASK));
  assign stall_s = ha_s | hb_s;
  // R0 writes never enter the scoreboard, so R0 sources never hazard.
  assign push_s  = bus.id_valid & bus.RW & ~stall_s & (bus.DA != {AW{1'b0}});

  assign bus.DHS_O     = stall_s;
  assign bus.DHS_I     = ~stall_s;
  assign bus.stall_cnt = stall_cnt_r;

`ifdef DHS_FWD_EN
  assign bus.fwd_a = bus.id_valid & ~bus.MA & match_a_s[DEPTH] & ~stall_s;
  assign bus.fwd_b = bus.id_valid & ~bus.MB & match_b_s[DEPTH] & ~stall_s;
`else
  assign bus.fwd_a = 1'b0;
  assign bus.fwd_b = 1'b0;
`endif

  // Scoreboard shift register. A stall pushes a bubble, and flush clears every valid bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_v_r <= '0;
      for (int k = 1; k <= DEPTH; k++) begin
        slot_dst_r[k] <= {AW{1'b0}};
      end
    end else if (bus.flush) begin
      slot_v_r <= '0;
    end else begin
      for (int k = DEPTH; k >= 2; k--) begin
        slot_v_r[k]   <= slot_v_r[k-1];
        slot_dst_r[k] <= slot_dst_r[k-1];
      end
      slot_v_r[1]   <= push_s;
      slot_dst_r[1] <= bus.DA;
    end
  end

  // Stall-cycle counter. It saturates at all-ones, and a clear takes priority over counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= {CW{1'b0}};
    end else if (bus.cnt_clr) begin
      stall_cnt_r <= {CW{1'b0}};
    end else if (stall_s && (stall_cnt_r != {CW{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + 1'b1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

endmodule

// File: tb/tb_dhs_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_dhs_scoreboard
// Directed test of dhs_scoreboard with AW=3, DEPTH=2 and CW=8. The
// expectations follow the DHS_FWD_EN setting of the build. Inputs change one
// time unit after the rising edge, and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_dhs_scoreboard;
  localparam int AW    = 3;
  localparam int DEPTH = 2;
  localparam int CW    = 8;
`ifdef DHS_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;
  int   found;

  dhs_scoreboard_if #(.AW(AW), .CW(CW)) bus ();

  dhs_scoreboard #(.AW(AW), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic drive(input logic v, input logic rw, input logic [AW-1:0] da,
                       input logic [AW-1:0] aa, input logic ma,
                       input logic [AW-1:0] ba, input logic mb);
    bus.id_valid = v;
    bus.RW       = rw;
    bus.DA       = da;
    bus.AA       = aa;
    bus.MA       = ma;
    bus.BA       = ba;
    bus.MB       = mb;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 3'd0, 1'b1);
    for (int i = 0; i < n; i++) adv();
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    bus.flush   = 1'b0;
    bus.cnt_clr = 1'b0;
    drive(1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 3'd0, 1'b1);
    #12;
    check("rst_dhs_o", 32'(bus.DHS_O), 32'd0);
    check("rst_dhs_i", 32'(bus.DHS_I), 32'd1);
    check("rst_cnt", 32'(bus.stall_cnt), 32'd0);
    check("rst_fwd_a", 32'(bus.fwd_a), 32'd0);
    adv();
    rst_n = 1'b1;
    idle(1);

    // RAW on A: write R3, then read R3.
    drive(1'b1, 1'b1, 3'd3, 3'd0, 1'b1, 3'd0, 1'b1);
    @(negedge clk); check("raw_c0", 32'(bus.DHS_O), 32'd0);
    adv();
    drive(1'b1, 1'b0, 3'd0, 3'd3, 1'b0, 3'd0, 1'b1);
    @(negedge clk); check("raw_c1_o", 32'(bus.DHS_O), 32'd1);
    check("raw_c1_i", 32'(bus.DHS_I), 32'd0);
    check("raw_c1_fwd", 32'(bus.fwd_a), 32'd0);
    adv();
    @(negedge clk); check("raw_c2_o", 32'(bus.DHS_O), FWD ? 32'd0 : 32'd1);
    check("raw_c2_fwd", 32'(bus.fwd_a), FWD ? 32'd1 : 32'd0);
    adv();
    @(negedge clk); check("raw_c3_o", 32'(bus.DHS_O), 32'd0);
    check("raw_c3_fwd", 32'(bus.fwd_a), 32'd0);
    check("raw_cnt", 32'(bus.stall_cnt), FWD ? 32'd1 : 32'd2);
    bus.cnt_clr = 1'b1;
    idle(1);
    bus.cnt_clr = 1'b0;
    check("cnt_clr", 32'(bus.stall_cnt), 32'd0);
    idle(2);

    // Masked operands: no hazard. Then unmask B while R3 sits in the oldest slot.
    drive(1'b1, 1'b1, 3'd3, 3'd0, 1'b1, 3'd0, 1'b1);
    adv();
    drive(1'b1, 1'b0, 3'd0, 3'd3, 1'b1, 3'd3, 1'b1);
    @(negedge clk); check("masked", 32'(bus.DHS_O), 32'd0);
    adv();
    drive(1'b1, 1'b0, 3'd0, 3'd3, 1'b1, 3'd3, 1'b0);
    @(negedge clk); check("b_old_o", 32'(bus.DHS_O), FWD ? 32'd0 : 32'd1);
    check("b_old_fwd", 32'(bus.fwd_b), FWD ? 32'd1 : 32'd0);
    idle(3);

    // R0 writes are never entered.
    drive(1'b1, 1'b1, 3'd0, 3'd0, 1'b1, 3'd0, 1'b1);
    adv();
    drive(1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0);
    @(negedge clk); check("r0_c1", 32'(bus.DHS_O), 32'd0);
    adv();
    @(negedge clk); check("r0_c2", 32'(bus.DHS_O), 32'd0);
    idle(2);

    // Flush: the pre-flush slots still stall in the flush cycle, and the hazard is gone afterwards.
    drive(1'b1, 1'b1, 3'd5, 3'd0, 1'b1, 3'd0, 1'b1);
    adv();
    drive(1'b1, 1'b0, 3'd0, 3'd0, 1'b1, 3'd5, 1'b0);
    bus.flush = 1'b1;
    @(negedge clk); check("flush_c1", 32'(bus.DHS_O), 32'd1);
    adv();
    bus.flush = 1'b0;
    @(negedge clk); check("flush_c2", 32'(bus.DHS_O), 32'd0);
    check("flush_c2_fwd", 32'(bus.fwd_b), 32'd0);
    // A write presented in a flush cycle is discarded.
    drive(1'b1, 1'b1, 3'd6, 3'd0, 1'b1, 3'd0, 1'b1);
    bus.flush = 1'b1;
    adv();
    bus.flush = 1'b0;
    drive(1'b1, 1'b0, 3'd0, 3'd6, 1'b0, 3'd0, 1'b1);
    @(negedge clk); check("flush_drop", 32'(bus.DHS_O), 32'd0);
    idle(2);

    // Saturation: a self-dependent write stream stalls repeatedly (more than 255 stall cycles in 600).
    bus.cnt_clr = 1'b1;
    idle(1);
    bus.cnt_clr = 1'b0;
    drive(1'b1, 1'b1, 3'd3, 3'd3, 1'b0, 3'd0, 1'b1);
    for (int i = 0; i < 600; i++) adv();
    found = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.DHS_O === 1'b1) begin
        found = 1;
        break;
      end
      adv();
    end
    check("sat_stall_found", 32'(found), 32'd1);
    check("sat_cnt", 32'(bus.stall_cnt), 32'd255);
    bus.cnt_clr = 1'b1;
    adv();
    bus.cnt_clr = 1'b0;
    drive(1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 3'd0, 1'b1);
    check("sat_clr", 32'(bus.stall_cnt), 32'd0);
    idle(3);

    // Reset asserted in the middle of a stall drops the stall at once.
    drive(1'b1, 1'b1, 3'd4, 3'd0, 1'b1, 3'd0, 1'b1);
    adv();
    drive(1'b1, 1'b0, 3'd0, 3'd4, 1'b0, 3'd0, 1'b1);
    @(negedge clk); check("mid_c1", 32'(bus.DHS_O), 32'd1);
    adv();
    @(negedge clk); check("mid_c2", 32'(bus.DHS_O), FWD ? 32'd0 : 32'd1);
    check("mid_cnt", 32'(bus.stall_cnt), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_o", 32'(bus.DHS_O), 32'd0);
    check("mid_rst_i", 32'(bus.DHS_I), 32'd1);
    check("mid_rst_cnt", 32'(bus.stall_cnt), 32'd0);
    check("mid_rst_fwd", 32'(bus.fwd_a), 32'd0);
    adv();
    rst_n = 1'b1;
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
